// File: rtl/send_arbiter_pkg.sv
// Shared definitions for the framing send-path arbiter and its round-robin picker.
package send_arbiter_pkg;

  localparam int unsigned SA_NREQ     = 4;
  localparam int unsigned SA_LEN_BITS = 6;

  typedef enum logic [1:0] {
    SA_IDLE   = 2'd0,
    SA_XFER   = 2'd1,
    SA_COMMIT = 2'd2
  } sa_state_e;

  // Index width for n requesters; never below one bit.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/send_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from last+1.
module rr_pick
  import send_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = SA_NREQ,
  parameter int unsigned IW   = idx_bits(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            found,
  output logic [IW-1:0]   idx
);

  // Walk from the farthest candidate back to last+1 so the nearest one wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      if (req[IW'((int'(last) + k) % int'(NREQ))]) begin
        found = 1'b1;
        idx   = IW'((int'(last) + k) % int'(NREQ));
      end
    end
  end

endmodule

// File: rtl/send_arbiter.sv
// Round-robin arbiter that copies one whole packet at a time from a granted
// source into the framing send ring, then commits its length to the length FIFO.
module send_arbiter
  import send_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = SA_NREQ,
  parameter int unsigned LEN_BITS = SA_LEN_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*LEN_BITS-1:0] req_len,
  input  logic [NREQ*8-1:0]        req_data,
  output logic [NREQ-1:0]          req_rd,
  output logic [NREQ-1:0]          req_done,
  output logic [7:0]               send_ring_data,
  output logic                     send_ring_wr_en,
  input  logic                     send_ring_full,
  output logic [LEN_BITS-1:0]      send_fifo_data,
  output logic                     send_fifo_wr_en,
  input  logic                     send_fifo_full,
  output logic                     busy
);

  localparam int unsigned IW = idx_bits(NREQ);

  sa_state_e           state_q, state_d;
  logic [IW-1:0]       grant_q, grant_d;
  logic [IW-1:0]       last_q, last_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [LEN_BITS-1:0] cnt_q, cnt_d;
  logic                drop_q, drop_d;
  logic                xfer_wr;
  logic                pick_found;
  logic [IW-1:0]       pick_idx;

  logic [LEN_BITS-1:0] len_arr  [NREQ];
  logic [7:0]          data_arr [NREQ];

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_unpack
    assign len_arr[g]  = req_len[g*LEN_BITS +: LEN_BITS];
    assign data_arr[g] = req_data[g*8 +: 8];
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state and transfer decode; the byte write depends combinationally on ring full.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    xfer_wr = 1'b0;
    case (state_q)
      SA_IDLE: begin
        if (pick_found && !send_fifo_full) begin
          grant_d = pick_idx;
          len_d   = len_arr[pick_idx];
          cnt_d   = '0;
          drop_d  = (len_arr[pick_idx] == '0);
          state_d = drop_d ? SA_COMMIT : SA_XFER;
        end
      end
      SA_XFER: begin
        if (!send_ring_full) begin
          xfer_wr = 1'b1;
          cnt_d   = cnt_q + LEN_BITS'(1);
          if (cnt_q == len_q - LEN_BITS'(1)) begin
            state_d = SA_COMMIT;
          end
        end
      end
      SA_COMMIT: begin
        last_d  = grant_q;
        state_d = SA_IDLE;
      end
      default: state_d = SA_IDLE;
    endcase
  end

  assign send_ring_wr_en = xfer_wr;
  assign send_ring_data  = xfer_wr ? data_arr[grant_q] : 8'h00;
  assign req_rd          = xfer_wr ? (NREQ'(1) << grant_q) : '0;

  // State plus registered commit strobes, which land in the COMMIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= SA_IDLE;
      grant_q         <= '0;
      last_q          <= IW'(NREQ - 1);
      len_q           <= '0;
      cnt_q           <= '0;
      drop_q          <= 1'b0;
      req_done        <= '0;
      send_fifo_wr_en <= 1'b0;
      send_fifo_data  <= '0;
      busy            <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      last_q          <= last_d;
      len_q           <= len_d;
      cnt_q           <= cnt_d;
      drop_q          <= drop_d;
      req_done        <= (state_d == SA_COMMIT) ? (NREQ'(1) << grant_d) : '0;
      send_fifo_wr_en <= (state_d == SA_COMMIT) && !drop_d;
      send_fifo_data  <= ((state_d == SA_COMMIT) && !drop_d) ? len_d : '0;
      busy            <= (state_d != SA_IDLE);
    end
  end

endmodule

// File: tb/tb_send_arbiter.sv
// Scoreboard bench for send_arbiter: requester models feed packets, a negedge
// monitor pops expected ring bytes, committed lengths and done pulses.
module tb_send_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LB   = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*LB-1:0]  req_len;
  logic [NREQ*8-1:0]   req_data;
  logic [NREQ-1:0]     req_rd;
  logic [NREQ-1:0]     req_done;
  logic [7:0]          send_ring_data;
  logic                send_ring_wr_en;
  logic                send_ring_full;
  logic [LB-1:0]       send_fifo_data;
  logic                send_fifo_wr_en;
  logic                send_fifo_full;
  logic                busy;

  always #5 clk = ~clk;

  send_arbiter #(.NREQ(NREQ), .LEN_BITS(LB)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .req_len         (req_len),
    .req_data        (req_data),
    .req_rd          (req_rd),
    .req_done        (req_done),
    .send_ring_data  (send_ring_data),
    .send_ring_wr_en (send_ring_wr_en),
    .send_ring_full  (send_ring_full),
    .send_fifo_data  (send_fifo_data),
    .send_fifo_wr_en (send_fifo_wr_en),
    .send_fifo_full  (send_fifo_full),
    .busy            (busy)
  );

  // Requester models: byte memory with a read pointer, pending flag held until done.
  logic [7:0]      mem  [NREQ][256];
  logic [7:0]      ptr  [NREQ];
  logic [LB-1:0]   lenv [NREQ];
  logic [NREQ-1:0] pend, load, kill;
  logic            tb_init;
  logic            mon_en;

  assign req = pend & ~kill;
  for (genvar g = 0; g < int'(NREQ); g++) begin : g_req
    assign req_len[g*LB +: LB] = lenv[g];
    assign req_data[g*8 +: 8]  = mem[g][ptr[g]];
  end

  always @(posedge clk) begin
    for (int i = 0; i < int'(NREQ); i++) begin
      if (tb_init) begin
        ptr[i]  <= 8'd0;
        pend[i] <= 1'b0;
      end else begin
        if (req_rd[i]) ptr[i] <= ptr[i] + 8'd1;
        if (load[i]) pend[i] <= 1'b1;
        else if (req_done[i]) pend[i] <= 1'b0;
      end
    end
  end

  logic [7:0]    exp_byte [$];
  int            exp_bidx [$];
  logic [LB-1:0] exp_len  [$];
  int            exp_done [$];
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: every ring write, FIFO commit and done pulse must match the scoreboard.
  logic [7:0]    m_byte;
  int            m_idx;
  logic [LB-1:0] m_len;
  always @(negedge clk) begin
    if (mon_en) begin
      if (send_ring_wr_en) begin
        if (exp_byte.size() == 0) begin
          check("ring_unexpected", 32'(send_ring_wr_en), 32'd0);
        end else begin
          m_byte = exp_byte.pop_front();
          m_idx  = exp_bidx.pop_front();
          check("ring_data", 32'(send_ring_data), 32'(m_byte));
          check("req_rd", 32'(req_rd), 32'd1 << m_idx);
        end
      end else begin
        check("rd_idle", 32'(req_rd), 32'd0);
      end
      if (send_fifo_wr_en) begin
        if (exp_len.size() == 0) begin
          check("fifo_unexpected", 32'(send_fifo_wr_en), 32'd0);
        end else begin
          m_len = exp_len.pop_front();
          check("fifo_data", 32'(send_fifo_data), 32'(m_len));
        end
      end
      if (req_done != '0) begin
        if (exp_done.size() == 0) begin
          check("done_unexpected", 32'(req_done), 32'd0);
        end else begin
          m_idx = exp_done.pop_front();
          check("req_done", 32'(req_done), 32'd1 << m_idx);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Load a packet at the requester's current pointer; expect n_exp bytes, and optionally the commit.
  task automatic add_pkt(input int i, input int len, input logic [7:0] base,
                         input int n_exp, input bit commit);
    for (int b = 0; b < len; b++) begin
      mem[i][8'(ptr[i] + 8'(b))] = base + 8'(b);
      if (b < n_exp) begin
        exp_byte.push_back(base + 8'(b));
        exp_bidx.push_back(i);
      end
    end
    lenv[i] = LB'(len);
    if (commit) begin
      if (len > 0) exp_len.push_back(LB'(len));
      exp_done.push_back(i);
    end
  endtask

  task automatic pulse_load(input logic [NREQ-1:0] m);
    load = m;
    cyc();
    load = '0;
  endtask

  task automatic wait_busy();
    bit ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("busy_timeout", 32'(busy), 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (exp_byte.size() == 0 && exp_len.size() == 0 && exp_done.size() == 0 && !busy) break;
    end
    check("drain", 32'(exp_byte.size() + exp_len.size() + exp_done.size()), 32'd0);
  endtask

  // Per-cycle strobe pattern from the first busy cycle; bit k of ps sets ring full for cycle k.
  task automatic run_pat(input string tag, input int n, input logic [15:0] pw,
                         input logic [15:0] pf, input logic [15:0] pb, input logic [15:0] ps);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        cyc();
        send_ring_full = ps[k];
        @(negedge clk);
      end
      check({tag, "_wr"}, 32'(send_ring_wr_en), 32'(pw[k]));
      check({tag, "_fifo"}, 32'(send_fifo_wr_en), 32'(pf[k]));
      check({tag, "_busy"}, 32'(busy), 32'(pb[k]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mon_en = 1'b0; rst = 1'b1; tb_init = 1'b1;
    load = '0; kill = '0;
    send_ring_full = 1'b0; send_fifo_full = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) lenv[i] = '0;
    repeat (3) @(posedge clk);
    #1 tb_init = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr", 32'(send_ring_wr_en), 32'd0);
    check("rst_rd", 32'(req_rd), 32'd0);
    check("rst_done", 32'(req_done), 32'd0);
    check("rst_fifo_wr", 32'(send_fifo_wr_en), 32'd0);
    check("rst_fifo_data", 32'(send_fifo_data), 32'd0);
    cyc();
    rst = 1'b0; mon_en = 1'b1;

    // Single packet, len 3: writes on busy cycles 0..2, commit on cycle 3.
    add_pkt(0, 3, 8'hA1, 3, 1'b1);
    pulse_load(4'b0001);
    wait_busy();
    run_pat("single", 5, 16'b00111, 16'b01000, 16'b01111, 16'b0);
    drain();

    // Backpressure: two stall cycles after byte 2 push the commit out by two cycles.
    cyc();
    add_pkt(1, 4, 8'hB1, 4, 1'b1);
    pulse_load(4'b0010);
    wait_busy();
    run_pat("stall", 8, 16'b0011_0011, 16'b0100_0000, 16'b0111_1111, 16'b0000_1100);
    drain();

    // Length FIFO full holds the arbiter idle; release grants on the next cycle.
    cyc();
    send_fifo_full = 1'b1;
    add_pkt(1, 2, 8'hC1, 2, 1'b1);
    pulse_load(4'b0010);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check("ffull_busy", 32'(busy), 32'd0);
      check("ffull_wr", 32'(send_ring_wr_en), 32'd0);
      cyc();
    end
    send_fifo_full = 1'b0;
    @(negedge clk);
    check("ffull_grant_cycle", 32'(busy), 32'd0);
    @(negedge clk);
    run_pat("ffull", 4, 16'b0011, 16'b0100, 16'b0111, 16'b0);
    drain();

    // Zero length: one COMMIT cycle with done only.
    cyc();
    add_pkt(2, 0, 8'h00, 0, 1'b1);
    pulse_load(4'b0100);
    wait_busy();
    run_pat("zero", 2, 16'b00, 16'b00, 16'b01, 16'b0);
    drain();

    // req dropped mid-transfer: all five bytes still go out and commit.
    cyc();
    add_pkt(3, 5, 8'h50, 5, 1'b1);
    pulse_load(4'b1000);
    wait_busy();
    cyc();
    cyc();
    kill = 4'b1000;
    drain();
    cyc();
    kill = '0;

    // Reset after two of five bytes: no commit, outputs clear, requester 0 first afterwards.
    add_pkt(0, 5, 8'h60, 2, 1'b0);
    pulse_load(4'b0001);
    wait_busy();
    cyc();
    rst = 1'b1;
    @(negedge clk);
    cyc();
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_wr", 32'(send_ring_wr_en), 32'd0);
    check("mid_rst_rd", 32'(req_rd), 32'd0);
    check("mid_rst_fifo_wr", 32'(send_fifo_wr_en), 32'd0);
    check("mid_rst_done", 32'(req_done), 32'd0);
    check("mid_rst_queue", 32'(exp_byte.size()), 32'd0);
    add_pkt(0, 2, 8'h70, 2, 1'b1);
    add_pkt(2, 1, 8'h80, 1, 1'b1);
    cyc();
    rst = 1'b0;
    pulse_load(4'b0100);
    drain();

    // Round-robin from a fresh reset: 0,1,2,3 then wrap back to 0 ahead of 3.
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) add_pkt(i, 1, 8'hD0 + 8'(i), 1, 1'b1);
    pulse_load(4'b1111);
    drain();
    cyc();
    add_pkt(0, 1, 8'hE0, 1, 1'b1);
    add_pkt(3, 1, 8'hE3, 1, 1'b1);
    pulse_load(4'b1001);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
